sample_stream_tx: RTL and testbench
===================================

SAMPLE_STREAM_TX -- requirements
Module: sample_stream_tx

Interface
REQ-001 The module SHALL have parameter NUM_UNITS, default 2: number of addressable units, legal range 1..4.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16: sample width, a multiple of 8, range 8..32; NBYTES = DATA_WIDTH/8.
REQ-003 The module SHALL have parameter GAP_CYCLES, default 1: idle cycles with byte_valid low after each byte, range 0..15.
REQ-004 The module SHALL have port clk  in  1  rising-edge clock.
REQ-005 The module SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 The module SHALL have port s_valid  in  1  sample offered.
REQ-007 The module SHALL have port s_ready  out  1  sample accepted when s_valid && s_ready at a rising edge.
REQ-008 The module SHALL have port s_data  in  DATA_WIDTH  sample value.
REQ-009 The module SHALL have port s_unit  in  2  destination unit index.
REQ-010 The module SHALL have port byte_out  out  8  serialized data byte (drives receiver data byte input).
REQ-011 The module SHALL have port byte_valid  out  1  byte strobe (drives receiver byte_valid).
REQ-012 The module SHALL have port unit_sel  out  2  unit selector (drives receiver selector).
REQ-013 The module SHALL have port busy  out  1  high while a sample is held or being sent.
REQ-014 The module SHALL have port drop  out  1  one-cycle pulse when an accepted s_unit >= NUM_UNITS is discarded.

Function
REQ-015 The module SHALL implement FSM states IDLE, SEND, GAP.
REQ-016 In IDLE, s_ready SHALL be 1; acceptance of a legal unit latches s_data into the shift register, latches s_unit into unit_sel, loads byte counter = NBYTES, and moves to SEND next cycle.
REQ-017 Acceptance with s_unit >= NUM_UNITS SHALL assert drop for exactly one cycle, latch nothing, and remain in IDLE.
REQ-018 In SEND, the module SHALL drive byte_out = the shift register MSB byte and byte_valid = 1 for exactly one cycle, then shift left by 8 and decrement the byte counter.
REQ-019 After SEND, the module SHALL enter GAP for GAP_CYCLES cycles if GAP_CYCLES > 0, otherwise go directly to the next SEND or to IDLE.
REQ-020 After the last byte and its gap, the module SHALL return to IDLE; the first s_ready = 1 SHALL occur in the cycle after the final GAP cycle (or after the final SEND if GAP_CYCLES = 0).
REQ-021 Byte order SHALL be MSB first: byte k (0-based) = s_data[DATA_WIDTH-1-8k -: 8].
REQ-022 s_ready SHALL be 0 in SEND and GAP; there is no skid buffer, and s_data/s_unit are ignored while s_ready = 0.
REQ-023 unit_sel SHALL be stable from the first byte through the last byte of a sample and SHALL hold its last value while in IDLE.
REQ-024 byte_out SHALL be 8'h00 whenever byte_valid = 0.
REQ-025 Latency SHALL be as follows: the first byte_valid occurs in the cycle after acceptance; with G = GAP_CYCLES, a sample occupies NBYTES*(1+G) cycles of SEND+GAP.
REQ-026 busy SHALL be 1 in SEND and GAP and 0 in IDLE.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously force IDLE with s_ready=1 after release, byte_valid=0, byte_out=0, unit_sel=0, busy=0, drop=0, counters=0.
REQ-028 Reset asserted mid-sample SHALL abort the sample with no further byte_valid; after release, no partial sample is resumed.

Configuration
REQ-029 When macro SAMPLE_STREAM_TX_STATS_EN is defined, the module SHALL add port sent_count  out  16, which increments once per completed sample (on its last byte), saturates at 16'hFFFF, and is reset to 0.
REQ-030 When SAMPLE_STREAM_TX_STATS_EN is not defined, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-031 The bench SHALL cover: defaults, s_data=16'hA5C3, s_unit=1 -> byte_valid high at cycles +1 and +3 with byte_out A5 then C3, unit_sel=1 throughout, s_ready high again at +5.
REQ-032 The bench SHALL cover: GAP_CYCLES=0, two back-to-back samples 16'h1234 (unit 0) and 16'hBEEF (unit 1) -> bytes 12,34 on consecutive cycles, s_ready high at +3, then BE,EF with unit_sel=1.
REQ-033 The bench SHALL cover: s_unit=3 with NUM_UNITS=2 -> drop pulses for 1 cycle, no byte_valid, FSM stays IDLE.
REQ-034 The bench SHALL cover: rst_n low one cycle after the first byte of 16'hFF00 -> byte_valid=0 immediately, no second byte, and after release s_ready=1 and unit_sel=0.
REQ-035 The bench SHALL cover: s_valid held high while busy with changing s_data -> only the accepted sample is transmitted, with no extra byte_valid.
REQ-036 The bench SHALL cover: SAMPLE_STREAM_TX_STATS_EN defined, 3 samples sent -> sent_count=3; reset -> 0.

Source files
------------

// File: rtl/sample_stream_tx.sv
// -----------------------------------------------------------------------------
// sample_stream_tx
//   Serialises one DATA_WIDTH-bit sample per handshake into bytes, MSB byte
//   first, for a byte-wide receiver. Each byte is shown on byte_out with
//   byte_valid high for exactly one cycle. After each byte there are
//   GAP_CYCLES idle cycles. unit_sel tells the receiver which unit the bytes
//   are for. A sample that targets a unit at or above NUM_UNITS is accepted
//   and thrown away, and drop pulses for one cycle.
//
// Optional feature (macro SAMPLE_STREAM_TX_STATS_EN):
//   Adds the sent_count output. It counts completed samples and saturates.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   sample offered
//   s_ready    out  high in IDLE; a sample is taken when s_valid && s_ready
//   s_data     in   sample value
//   s_unit     in   destination unit index
//   byte_out   out  serialised byte; 8'h00 whenever byte_valid is low
//   byte_valid out  one-cycle strobe per byte
//   unit_sel   out  unit of the current or last sample
//   busy       out  high while a sample is held or being sent
//   drop       out  one-cycle pulse, in the cycle after an illegal unit is taken
//   sent_count out  completed-sample count (only with SAMPLE_STREAM_TX_STATS_EN)
//   dbg_state  out  current FSM state (IDLE=0, SEND=1, GAP=2)
//
// Handshake: s_valid/s_ready use strict valid/ready semantics. A transfer
//   happens on a rising edge where both are high. s_ready does not depend on
//   s_valid. There is no skid buffer, so s_data and s_unit are ignored while
//   s_ready is low.
// -----------------------------------------------------------------------------
module sample_stream_tx #(
  parameter int NUM_UNITS  = 2,
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [1:0]            s_unit,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic [1:0]            unit_sel,
  output logic                  busy,
  output logic                  drop,
`ifdef SAMPLE_STREAM_TX_STATS_EN
  output logic [15:0]           sent_count,
`endif
  output logic [1:0]            dbg_state
);

  localparam int          NBYTES      = DATA_WIDTH / 8;
  localparam logic [2:0]  NBYTES_L    = 3'(NBYTES);
  localparam logic [2:0]  NUM_UNITS_L = 3'(NUM_UNITS);
  localparam logic [3:0]  GAP_L       = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            unit_q,  unit_d;
  logic [2:0]            bcnt_q,  bcnt_d;   // bytes still to send, including the current one
  logic [3:0]            gcnt_q,  gcnt_d;   // gap cycles remaining
  logic                  drop_q,  drop_d;
  logic                  unit_legal;

  assign unit_legal = ({1'b0, s_unit} < NUM_UNITS_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      unit_q  <= 2'd0;
      bcnt_q  <= 3'd0;
      gcnt_q  <= 4'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      unit_q  <= unit_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    unit_d  = unit_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (unit_legal) begin
            shift_d = s_data;
            unit_d  = s_unit;
            bcnt_d  = NBYTES_L;
            state_d = SEND;
          end else begin
            // Illegal unit: nothing is latched and the FSM stays in IDLE.
            drop_d = 1'b1;
          end
        end
      end
      SEND: begin
        shift_d = shift_q << 8;
        bcnt_d  = bcnt_q - 3'd1;
        if (GAP_CYCLES > 0) begin
          gcnt_d  = GAP_L;
          state_d = GAP;
        end else if (bcnt_q == 3'd1) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - 4'd1;
        if (gcnt_q == 4'd1) begin
          // bcnt_q was already decremented in SEND, so zero means the last byte is done.
          state_d = (bcnt_q == 3'd0) ? IDLE : SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready    = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign byte_valid = (state_q == SEND);
  assign byte_out   = (state_q == SEND) ? shift_q[DATA_WIDTH-1 -: 8] : 8'h00;
  assign unit_sel   = unit_q;
  assign drop       = drop_q;
  assign dbg_state  = state_q;

`ifdef SAMPLE_STREAM_TX_STATS_EN
  logic [15:0] sent_q, sent_d;

  // The count steps on the edge that ends the last SEND of a sample.
  always_comb begin
    sent_d = sent_q;
    if (state_q == SEND && bcnt_q == 3'd1 && sent_q != 16'hFFFF) begin
      sent_d = sent_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent_q <= 16'd0;
    else        sent_q <= sent_d;
  end

  assign sent_count = sent_q;
`endif

endmodule

// File: tb/tb_sample_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_sample_stream_tx
//   Two instances share the clock and reset. u0 uses the default parameters
//   (GAP_CYCLES=1). u1 uses GAP_CYCLES=0. Directed scenarios check fixed
//   timelines. The random scenario checks every cycle against a schedule
//   model, and a byte queue checks the order of the bytes sent.
// -----------------------------------------------------------------------------
module tb_sample_stream_tx;

  localparam int DW = 16;
  localparam int NB = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // per-DUT signals, index 0 -> u0, index 1 -> u1
  logic [1:0]          sv;
  logic [1:0][DW-1:0]  sd;
  logic [1:0][1:0]     su;
  logic [1:0]          srdy;
  logic [1:0][7:0]     bo;
  logic [1:0]          bv;
  logic [1:0][1:0]     us;
  logic [1:0]          busy;
  logic [1:0]          drp;
  logic [1:0][1:0]     dbg;
`ifdef SAMPLE_STREAM_TX_STATS_EN
  logic [1:0][15:0]    sc;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  sample_stream_tx #(.NUM_UNITS(2), .DATA_WIDTH(DW), .GAP_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(srdy[0]), .s_data(sd[0]),
    .s_unit(su[0]), .byte_out(bo[0]), .byte_valid(bv[0]), .unit_sel(us[0]),
    .busy(busy[0]), .drop(drp[0]),
`ifdef SAMPLE_STREAM_TX_STATS_EN
    .sent_count(sc[0]),
`endif
    .dbg_state(dbg[0])
  );

  sample_stream_tx #(.NUM_UNITS(2), .DATA_WIDTH(DW), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(srdy[1]), .s_data(sd[1]),
    .s_unit(su[1]), .byte_out(bo[1]), .byte_valid(bv[1]), .unit_sel(us[1]),
    .busy(busy[1]), .drop(drp[1]),
`ifdef SAMPLE_STREAM_TX_STATS_EN
    .sent_count(sc[1]),
`endif
    .dbg_state(dbg[1])
  );

  // driver: reset pulse; returns at the negedge where reset has just been released
  task automatic do_reset();
    @(negedge clk);
    sv = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sv = 2'b00;
    sd = '0;
    su = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bv[d] !== 1'b0 || bo[d] !== 8'h00 || us[d] !== 2'd0 || busy[d] !== 1'b0 || drp[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got bv=%b bo=%h us=%0d busy=%b drop=%b required all zero",
                 d, bv[d], bo[d], us[d], busy[d], drp[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (srdy[d] !== 1'b1 || dbg[d] !== 2'd0) begin
        failures++;
        $display("FAIL reset_release dut%0d got s_ready=%b state=%0d required s_ready=1 state=0", d, srdy[d], dbg[d]);
      end
    end
  endtask

  // A5C3 to unit 1 with one gap cycle: bytes at +1 and +3, ready again at +5
  task automatic test_basic();
    logic       e_bv [6];
    logic [7:0] e_bo [6];
    logic       e_rd [6];
    logic       e_bz [6];
    e_bv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    e_bo = '{8'h00, 8'hA5, 8'h00, 8'hC3, 8'h00, 8'h00};
    e_rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    sd[0] = 16'hA5C3;
    su[0] = 2'd1;
    sv[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        sv[0] = 1'b0;
      end
      checks++;
      if (bv[0] !== e_bv[i] || bo[0] !== e_bo[i] || srdy[0] !== e_rd[i] || busy[0] !== e_bz[i]) begin
        failures++;
        $display("FAIL basic_t+%0d got bv=%b bo=%h rdy=%b busy=%b required bv=%b bo=%h rdy=%b busy=%b",
                 i, bv[0], bo[0], srdy[0], busy[0], e_bv[i], e_bo[i], e_rd[i], e_bz[i]);
      end
      if (i > 0) begin
        checks++;
        if (us[0] !== 2'd1) begin
          failures++;
          $display("FAIL basic_unit_t+%0d got unit_sel=%0d required 1", i, us[0]);
        end
      end
    end
  endtask

  // GAP_CYCLES=0: 1234 to unit 0 then BEEF to unit 1 as soon as ready returns.
  // BEEF is offered early on purpose; it must be ignored until s_ready is high.
  task automatic test_back_to_back();
    logic       e_bv [7];
    logic [7:0] e_bo [7];
    logic       e_rd [7];
    logic [1:0] e_us [7];
    e_bv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    e_bo = '{8'h00, 8'h12, 8'h34, 8'h00, 8'hBE, 8'hEF, 8'h00};
    e_rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    e_us = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    do_reset();
    sd[1] = 16'h1234;
    su[1] = 2'd0;
    sv[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin
        sd[1] = 16'hBEEF;
        su[1] = 2'd1;
      end
      if (i == 4) sv[1] = 1'b0;
      checks++;
      if (bv[1] !== e_bv[i] || bo[1] !== e_bo[i] || srdy[1] !== e_rd[i] || us[1] !== e_us[i]) begin
        failures++;
        $display("FAIL b2b_t+%0d got bv=%b bo=%h rdy=%b us=%0d required bv=%b bo=%h rdy=%b us=%0d",
                 i, bv[1], bo[1], srdy[1], us[1], e_bv[i], e_bo[i], e_rd[i], e_us[i]);
      end
    end
  endtask

  // Illegal units 3 and 2 (NUM_UNITS=2): each gives a one-cycle drop and nothing else.
  task automatic test_drop();
    logic e_dr [8];
    e_dr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    sd[0] = 16'($urandom);
    su[0] = 2'd3;
    sv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      sv[0] = (i == 0 || i == 3);
      if (i == 3) su[0] = 2'd2;
      checks++;
      if (drp[0] !== e_dr[i] || bv[0] !== 1'b0 || srdy[0] !== 1'b1 || busy[0] !== 1'b0 ||
          us[0] !== 2'd0 || dbg[0] !== 2'd0) begin
        failures++;
        $display("FAIL drop_t+%0d got drop=%b bv=%b rdy=%b busy=%b us=%0d state=%0d required drop=%b bv=0 rdy=1 busy=0 us=0 state=0",
                 i, drp[0], bv[0], srdy[0], busy[0], us[0], dbg[0], e_dr[i]);
      end
    end
  endtask

  // Reset one cycle after the first byte of FF00: no second byte and no resumption.
  task automatic test_reset_mid();
    do_reset();
    sd[0] = 16'hFF00;
    su[0] = 2'd1;
    sv[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    checks++;
    if (bv[0] !== 1'b1 || bo[0] !== 8'hFF || us[0] !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_first got bv=%b bo=%h us=%0d required bv=1 bo=ff us=1", bv[0], bo[0], us[0]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bv[0] !== 1'b0 || bo[0] !== 8'h00 || us[0] !== 2'd0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got bv=%b bo=%h us=%0d busy=%b required 0 0 0 0", bv[0], bo[0], us[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (srdy[0] !== 1'b1 || us[0] !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_release got rdy=%b us=%0d required rdy=1 us=0", srdy[0], us[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bv[0] !== 1'b0 || busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_noresume_t+%0d got bv=%b busy=%b required 0 0", i, bv[0], busy[0]);
      end
    end
  endtask

  // s_valid held high with new data every cycle: only the first sample goes out.
  task automatic test_hold_valid();
    logic [15:0] first;
    logic [1:0]  unit;
    logic        e_bv [8];
    logic [7:0]  e_bo [8];
    do_reset();
    first = 16'($urandom);
    unit  = 2'($urandom_range(0, 1));
    e_bv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e_bo = '{8'h00, first[15:8], 8'h00, first[7:0], 8'h00, 8'h00, 8'h00, 8'h00};
    sd[0] = first;
    su[0] = unit;
    sv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        sd[0] = 16'($urandom);
        su[0] = 2'($urandom_range(0, 1));
        sv[0] = (i < 5);
      end
      checks++;
      if (bv[0] !== e_bv[i] || bo[0] !== e_bo[i] || (i > 0 && us[0] !== unit)) begin
        failures++;
        $display("FAIL hold_t+%0d got bv=%b bo=%h us=%0d required bv=%b bo=%h us=%0d",
                 i, bv[0], bo[0], us[0], e_bv[i], e_bo[i], unit);
      end
    end
  endtask

`ifdef SAMPLE_STREAM_TX_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (sc[0] !== 16'd0) begin
      failures++;
      $display("FAIL stats_initial got %0d required 0", sc[0]);
    end
    for (int n = 0; n < 3; n++) begin
      sd[0] = 16'($urandom);
      su[0] = 2'($urandom_range(0, 1));
      sv[0] = 1'b1;
      @(negedge clk);
      sv[0] = 1'b0;
      repeat (5) @(negedge clk);
    end
    checks++;
    if (sc[0] !== 16'd3) begin
      failures++;
      $display("FAIL stats_three got %0d required 3", sc[0]);
    end
    do_reset();
    checks++;
    if (sc[0] !== 16'd0) begin
      failures++;
      $display("FAIL stats_reset got %0d required 0", sc[0]);
    end
  endtask
`endif

  // Random traffic on both DUTs. The model only tracks when the current sample
  // started. Every output in a cycle follows from the offset into that sample
  // and the rule "one byte, then G idle cycles".
  task automatic test_random();
    int          start   [2];
    int          drop_c  [2];
    logic [15:0] mdata   [2];
    logic [1:0]  munit   [2];
    do_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      start[d]  = -100;
      drop_c[d] = -1;
      mdata[d]  = 16'h0000;
      munit[d]  = 2'd0;
    end
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int         g;
        int         span;
        int         off;
        logic       act;
        logic       ebv;
        logic [7:0] eb;
        logic       edr;
        logic [7:0] qb;
        g    = (d == 0) ? 1 : 0;
        span = NB * (1 + g);
        off  = c - start[d];
        act  = (off >= 0) && (off < span);
        ebv  = act && ((off % (1 + g)) == 0);
        eb   = ebv ? 8'(mdata[d] >> (8 * (NB - 1 - off / (1 + g)))) : 8'h00;
        edr  = (c == drop_c[d]);
        checks++;
        if (bv[d] !== ebv || bo[d] !== eb || srdy[d] !== !act || busy[d] !== act ||
            drp[d] !== edr || us[d] !== munit[d]) begin
          failures++;
          $display("FAIL rand_dut%0d cyc=%0d got bv=%b bo=%h rdy=%b busy=%b drop=%b us=%0d required bv=%b bo=%h rdy=%b busy=%b drop=%b us=%0d",
                   d, c, bv[d], bo[d], srdy[d], busy[d], drp[d], us[d], ebv, eb, !act, act, edr, munit[d]);
        end
        if (bv[d] === 1'b1) begin
          checks++;
          if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            failures++;
            $display("FAIL rand_sb_dut%0d cyc=%0d got byte %h required no byte", d, c, bo[d]);
          end else begin
            qb = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (bo[d] !== qb) begin
              failures++;
              $display("FAIL rand_sb_dut%0d cyc=%0d got byte %h required %h", d, c, bo[d], qb);
            end
          end
        end
        // stimulus for this cycle; the model takes the sample if it is idle now
        sv[d] = (c < 590) && ($urandom_range(0, 2) != 0);
        sd[d] = 16'($urandom);
        su[d] = 2'($urandom_range(0, 3));
        if (sv[d] && !act) begin
          if (su[d] < 2'd2) begin
            start[d] = c + 1;
            mdata[d] = sd[d];
            munit[d] = su[d];
            for (int k = 0; k < NB; k++) begin
              if (d == 0) exp_q0.push_back(8'(sd[d] >> (8 * (NB - 1 - k))));
              else        exp_q1.push_back(8'(sd[d] >> (8 * (NB - 1 - k))));
            end
          end else begin
            drop_c[d] = c + 1;
          end
        end
      end
    end
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL rand_drain got pending=%0d/%0d required 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_hold_valid();
`ifdef SAMPLE_STREAM_TX_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
